sap_controller: RTL and testbench
=================================

Name: sap_controller

Overview:
Controller-sequencer for the 8-bit SAP accumulator machine. A 6-state ring counter (T1..T6) generates the fetch phase, then decodes the 4-bit opcode held in the instruction register. It drives every control line of the shared W bus datapath: PC, MAR, RAM, IR, A, ALU, B and output register. It also provides run/single-step control and halt handling.

Parameters:
OP_LDA, 4'b0000, opcode for load accumulator from RAM
OP_ADD, 4'b0001, opcode for A <= A + RAM[addr]
OP_SUB, 4'b0010, opcode for A <= A - RAM[addr]
OP_OUT, 4'b1110, opcode for output register <= A
OP_HLT, 4'b1111, opcode for stop sequencing

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low; also forwarded as clr_n
run  in  1  1: advance one T-state per clock; 0: single-step mode
step  in  1  asynchronous pushbutton; each rising edge advances one T-state when run=0
opcode  in  4  IR upper nibble, valid during T4..T6
cp  out  1  PC increment (active-high)
ep  out  1  PC drives W bus (active-high)
lm_n  out  1  MAR load (active-low)
ce_n  out  1  RAM drives W bus (active-low)
li_n  out  1  IR load (active-low)
ei_n  out  1  IR address nibble drives W bus (active-low)
la_n  out  1  A load (active-low)
ea  out  1  A drives W bus (active-high)
su  out  1  ALU subtract select (active-high)
eu  out  1  ALU drives W bus (active-high)
load_b  out  1  B load (active-low)
load_out  out  1  output register load (active-low)
clr_n  out  1  copy of reset for datapath registers
t_state  out  6  one-hot current T-state; bit0 = T1
halted  out  1  1 once HLT has executed

Behaviour:
- State: one-hot ring T1..T6 plus HALT. Asynchronous reset (reset=0) sets state to T1 and clears halted and the step synchronizer.
- While reset=0, all control outputs are at their inactive levels: active-high lines 0, active-low lines 1. t_state=6'b000001.
- Control outputs are combinational from state and opcode (Moore on T-state). They are stable for a whole cycle, and the datapath samples them on the next rising edge.
- Advance condition (adv): run=1, or run=0 with a detected rising edge of step.
  - step passes through a 2-flop synchronizer plus edge detect. One press gives exactly one adv pulse.
  - While run=1, step is ignored.
- On adv: T1->T2->...->T6->T1. If adv is not asserted, state holds.
- Control per state; unlisted lines are inactive:
  - T1: ep=1, lm_n=0.
  - T2: cp=1.
  - T3: ce_n=0, li_n=0.
  - T4, LDA/ADD/SUB: ei_n=0, lm_n=0.
  - T4, OUT: ea=1, load_out=0.
  - T4, HLT: none; the next adv goes to HALT.
  - T5, LDA: ce_n=0, la_n=0.
  - T5, ADD/SUB: ce_n=0, load_b=0.
  - T5, OUT: none.
  - T6, ADD: eu=1, la_n=0.
  - T6, SUB: su=1, eu=1, la_n=0.
  - T6, LDA/OUT: none.
- Undefined opcodes: T4..T6 are NOPs and the ring continues to T1.
- Step-mode gating: cp, and every load strobe (lm_n, li_n, la_n, load_b, load_out), is asserted only in a cycle where adv=1. Bus-enable lines (ep, ce_n, ei_n, ea, eu, su) follow the state regardless. As a result, each load happens exactly once per step.
- HALT: all controls inactive, halted=1, t_state=6'b000000. Only reset leaves HALT; run and step are ignored.
- Bus invariant: at most one of ep, !ce_n, !ei_n, ea, eu is active in any cycle. Verification checks this as an assertion.
- Reset mid-instruction: returns to T1 immediately, with no partial load strobes after reset is asserted.
- clr_n = reset (combinational).

Test Plan:
- Reset then run=1, opcode=OP_LDA: t_state cycles 01,02,04,08,10,20,01. In T1 ep=1/lm_n=0; T2 cp=1; T3 ce_n=0/li_n=0; T4 ei_n=0/lm_n=0; T5 ce_n=0/la_n=0; T6 all inactive.
- opcode=OP_SUB, run=1: in T5 load_b=0 and ce_n=0; in T6 su=1, eu=1, la_n=0. OP_ADD gives the same with su=0.
- opcode=OP_OUT: T4 gives ea=1, load_out=0; T5 and T6 all inactive. opcode=4'b0111 gives T4..T6 all inactive, then back to T1.
- opcode=OP_HLT: after T4 the next cycle has halted=1 and t_state=0, with no further change over 20 clocks under run/step toggling. reset=0 then gives t_state=01 and halted=0.
- run=0, three step pulses each 5 clocks wide: state advances exactly 3 times (T1->T4). lm_n is low for exactly 1 clock per relevant step.
- reset=0 asserted asynchronously mid-T5 of LDA: la_n goes to 1 immediately and t_state=01. Across all tests, the bus-driver mutual exclusion assertion never fires.

Source files
------------

// File: rtl/sap_controller.sv
// sap_controller: T-state sequencer and instruction decoder for the 8-bit SAP machine.
// Ports:
//   clock, reset (async active-low), run (free-run / single-step), step (pushbutton)
//   opcode   : IR upper nibble, decoded in T4..T6
//   cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, load_b, load_out : datapath controls
//   clr_n    : reset forwarded to datapath registers
//   t_state  : one-hot T-state (bit0 = T1), zero when halted
//   halted   : set once HLT has executed
module sap_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm_n,
    output logic       ce_n,
    output logic       li_n,
    output logic       ei_n,
    output logic       la_n,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       load_b,
    output logic       load_out,
    output logic       clr_n,
    output logic [5:0] t_state,
    output logic       halted
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot encoding: low six bits are the visible T-state, bit 6 is HALT.
    typedef enum logic [6:0] {
        S_T1   = 7'b0000001,
        S_T2   = 7'b0000010,
        S_T3   = 7'b0000100,
        S_T4   = 7'b0001000,
        S_T5   = 7'b0010000,
        S_T6   = 7'b0100000,
        S_HALT = 7'b1000000
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   step_s1;
    logic   step_s2;
    logic   step_d;
    logic   adv;
    logic   mem_op;

    // Step pushbutton synchronizer plus rising-edge delay flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            step_d  <= step_s2;
        end
    end

    // Step edges only matter in single-step mode; run=1 advances every clock.
    assign adv    = run | (step_s2 & ~step_d);
    assign mem_op = (opcode == OP_LDA) | (opcode == OP_ADD) | (opcode == OP_SUB);

    assign clr_n   = reset;
    assign t_state = state[5:0];
    assign halted  = state[6];

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_T1;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control decode; load strobes only fire in cycles that advance.
    always_comb begin
        state_nxt = state;
        cp        = 1'b0;
        ep        = 1'b0;
        lm_n      = 1'b1;
        ce_n      = 1'b1;
        li_n      = 1'b1;
        ei_n      = 1'b1;
        la_n      = 1'b1;
        ea        = 1'b0;
        su        = 1'b0;
        eu        = 1'b0;
        load_b    = 1'b1;
        load_out  = 1'b1;
        // Controls are forced inactive for as long as reset is held.
        if (reset) begin
            case (state)
                S_T1: begin
                    ep   = 1'b1;
                    lm_n = ~adv;
                    if (adv) state_nxt = S_T2;
                end
                S_T2: begin
                    cp = adv;
                    if (adv) state_nxt = S_T3;
                end
                S_T3: begin
                    ce_n = 1'b0;
                    li_n = ~adv;
                    if (adv) state_nxt = S_T4;
                end
                S_T4: begin
                    if (mem_op) begin
                        ei_n = 1'b0;
                        lm_n = ~adv;
                    end else if (opcode == OP_OUT) begin
                        ea       = 1'b1;
                        load_out = ~adv;
                    end
                    if (adv) state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
                end
                S_T5: begin
                    if (opcode == OP_LDA) begin
                        ce_n = 1'b0;
                        la_n = ~adv;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ce_n   = 1'b0;
                        load_b = ~adv;
                    end
                    if (adv) state_nxt = S_T6;
                end
                S_T6: begin
                    if (opcode == OP_ADD) begin
                        eu   = 1'b1;
                        la_n = ~adv;
                    end else if (opcode == OP_SUB) begin
                        su   = 1'b1;
                        eu   = 1'b1;
                        la_n = ~adv;
                    end
                    if (adv) state_nxt = S_T1;
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_T1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: randomized self-checking bench for sap_controller against a
// phase-number reference model of the SAP controller.
module tb_sap_controller;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [11:0] CTRL_IDLE = 12'h3E3;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, load_b, load_out, clr_n;
    logic [5:0] t_state;
    logic       halted;

    sap_controller dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .opcode   (opcode),
        .cp       (cp),
        .ep       (ep),
        .lm_n     (lm_n),
        .ce_n     (ce_n),
        .li_n     (li_n),
        .ei_n     (ei_n),
        .la_n     (la_n),
        .ea       (ea),
        .su       (su),
        .eu       (eu),
        .load_b   (load_b),
        .load_out (load_out),
        .clr_n    (clr_n),
        .t_state  (t_state),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    wire [11:0] ctrl = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, load_b, load_out};
    wire [2:0]  n_bus = 3'(ep) + 3'(!ce_n) + 3'(!ei_n) + 3'(ea) + 3'(eu);

    int checks = 0;
    int errors = 0;
    int lm_lows, li_lows, cp_highs;

    // Reference model: instruction phase 1..6, halt flag, last three sampled step values.
    int ph;
    bit hlt;
    bit h0, h1, h2;
    bit adv_now;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph  = 1;
        hlt = 1'b0;
        h0  = 1'b0;
        h1  = 1'b0;
        h2  = 1'b0;
    endtask

    function automatic logic [11:0] exp_ctrl(input int p, input bit hl, input logic [3:0] op,
                                             input bit a, input bit rst);
        bit c_p = 0, e_p = 0, l_m = 0, c_e = 0, l_i = 0, e_i = 0, l_a = 0;
        bit e_a = 0, s_u = 0, e_u = 0, l_b = 0, l_o = 0;
        if (rst && !hl) begin
            case (p)
                1: begin e_p = 1; l_m = a; end
                2: c_p = a;
                3: begin c_e = 1; l_i = a; end
                4: if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin e_i = 1; l_m = a; end
                   else if (op == OP_OUT) begin e_a = 1; l_o = a; end
                5: if (op == OP_LDA) begin c_e = 1; l_a = a; end
                   else if (op == OP_ADD || op == OP_SUB) begin c_e = 1; l_b = a; end
                6: if (op == OP_ADD) begin e_u = 1; l_a = a; end
                   else if (op == OP_SUB) begin s_u = 1; e_u = 1; l_a = a; end
                default: ;
            endcase
        end
        return {c_p, e_p, !l_m, !c_e, !l_i, !e_i, !l_a, e_a, s_u, e_u, !l_b, !l_o};
    endfunction

    function automatic logic [5:0] exp_t();
        if (hlt) return 6'd0;
        return 6'(1 << (ph - 1));
    endfunction

    // One clock: compare outputs mid-cycle, then step the model at the rising edge.
    task automatic cycle();
        @(negedge clock);
        adv_now = run || (h1 && !h2);
        check("ctrl", 32'(ctrl), 32'(exp_ctrl(ph, hlt, opcode, adv_now, reset)));
        check("t_state", 32'(t_state), 32'(exp_t()));
        check("halted", 32'(halted), 32'(hlt));
        check("clr_n", 32'(clr_n), 32'(reset));
        check("bus_excl", 32'(n_bus <= 3'd1), 32'd1);
        if (!lm_n) lm_lows++;
        if (!li_n) li_lows++;
        if (cp) cp_highs++;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            if (!hlt && adv_now) begin
                if (ph == 4 && opcode == OP_HLT) hlt = 1'b1;
                else ph = (ph == 6) ? 1 : ph + 1;
            end
            h2 = h1;
            h1 = h0;
            h0 = step;
        end
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_reset();
        assert_reset();
        cycle();
        reset = 1'b1;
    endtask

    logic [3:0] dir_ops [5] = '{OP_LDA, OP_ADD, OP_SUB, OP_OUT, 4'b0111};

    initial begin
        run    = 1'b0;
        step   = 1'b0;
        opcode = OP_LDA;
        assert_reset();
        cycle();
        cycle();
        check("rst_t_state", 32'(t_state), 32'h01);
        check("rst_ctrl", 32'(ctrl), 32'(CTRL_IDLE));

        // Free-running passes through each instruction class.
        foreach (dir_ops[k]) begin
            opcode = dir_ops[k];
            run    = 1'b1;
            do_reset();
            repeat (7) cycle();
        end

        // HLT: locks up until reset regardless of run/step.
        opcode = OP_HLT;
        run    = 1'b1;
        do_reset();
        repeat (4) cycle();
        repeat (20) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            cycle();
        end
        check("halt_t_state", 32'(t_state), 32'h00);
        check("halt_flag", 32'(halted), 32'd1);
        run  = 1'b0;
        step = 1'b0;
        do_reset();
        check("unhalt_t_state", 32'(t_state), 32'h01);
        check("unhalt_flag", 32'(halted), 32'd0);

        // Single-step: three wide presses advance exactly three states.
        opcode   = OP_LDA;
        lm_lows  = 0;
        li_lows  = 0;
        cp_highs = 0;
        repeat (3) begin
            step = 1'b1;
            repeat (5) cycle();
            step = 1'b0;
            repeat (5) cycle();
        end
        check("step_t_state", 32'(t_state), 32'h08);
        check("step_lm_lows", 32'(lm_lows), 32'd1);
        check("step_li_lows", 32'(li_lows), 32'd1);
        check("step_cp_highs", 32'(cp_highs), 32'd1);

        // Asynchronous reset in the middle of LDA T5.
        run = 1'b1;
        do_reset();
        for (int n = 0; n < 10 && ph != 5; n++) cycle();
        #2;
        check("pre_rst_la_n", 32'(la_n), 32'd0);
        reset = 1'b0;
        #1;
        check("async_la_n", 32'(la_n), 32'd1);
        check("async_t_state", 32'(t_state), 32'h01);
        check("async_ctrl", 32'(ctrl), 32'(CTRL_IDLE));
        model_reset();
        cycle();
        reset = 1'b1;

        // Random mix of run/step, opcodes and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) run = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) step = ~step;
            if (ph == 1 && !hlt) opcode = 4'($urandom_range(0, 15));
            if ((hlt && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) assert_reset();
            else reset = 1'b1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
